// File: rtl/rl_pair_scheduler.sv
// Pair scheduler for the range-limited force unit: loads a reference group into the filter
// lanes, streams every neighbor past them, then drains the buffers before the next group.
module rl_pair_scheduler #(
  parameter int unsigned NumFilter = 8,
  parameter int unsigned IdWidth   = 8,
  parameter int unsigned DrainWait = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [IdWidth-1:0]   num_ref_i,
  input  logic [IdWidth-1:0]   num_nb_i,
  input  logic [IdWidth-1:0]   num_home_i,
  output logic                 ref_rd_en_o,
  output logic [IdWidth-1:0]   ref_rd_addr_o,
  output logic [NumFilter-1:0] ref_latch_en_o,
  output logic                 nb_rd_en_o,
  output logic [IdWidth-1:0]   nb_rd_addr_o,
  output logic [NumFilter-1:0] pair_valid_o,
  output logic [IdWidth-1:0]   nb_particle_id_o,
  output logic [IdWidth-1:0]   ref_particle_id_o,
  input  logic [NumFilter-1:0] back_pressure_i,
  input  logic                 all_buffer_empty_i,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned CntW   = IdWidth + 1;
  localparam int unsigned SlotW  = (NumFilter > 1) ? $clog2(NumFilter) : 1;
  localparam int unsigned DrainW = (DrainWait > 0) ? $clog2(DrainWait + 1) : 1;
  localparam logic [SlotW-1:0]  LastSlot  = SlotW'(NumFilter - 1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DrainWait);

  typedef enum logic [2:0] {StIdle, StLoadRef, StPair, StDrain, StNext, StDone} state_e;

  state_e               state_q, state_d;
  logic [IdWidth-1:0]   num_ref_q, num_ref_d, num_nb_q, num_nb_d, num_home_q, num_home_d;
  logic [CntW-1:0]      base_q, base_d, cnt_q, cnt_d;
  logic [SlotW-1:0]     slot_q, slot_d;
  logic [DrainW-1:0]    drain_q, drain_d;
  logic [NumFilter-1:0] active_q, active_d, latch_q, latch_d, pv_q, pv_d;
  logic [IdWidth-1:0]   nb_id_q, nb_id_d;
  logic                 done_q, done_d;

  logic [CntW-1:0]      slot_base, base_inc;
  logic [NumFilter-1:0] home_mask;
  logic                 stall;

  assign slot_base = base_q + CntW'(slot_q);
  assign base_inc  = base_q + CntW'(NumFilter);
  assign stall     = |(back_pressure_i & active_q);

  // Home-cell neighbors pair only with lower-indexed references: no self pairs, no duplicates.
  always_comb begin
    home_mask = '1;
    if (cnt_q < {1'b0, num_home_q}) begin
      for (int unsigned s = 0; s < NumFilter; s++) begin
        home_mask[s] = (base_q + CntW'(s)) < cnt_q;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    num_ref_d     = num_ref_q;
    num_nb_d      = num_nb_q;
    num_home_d    = num_home_q;
    base_d        = base_q;
    cnt_d         = cnt_q;
    slot_d        = slot_q;
    drain_d       = drain_q;
    active_d      = active_q;
    latch_d       = '0;
    pv_d          = '0;
    nb_id_d       = nb_id_q;
    ref_rd_en_o   = 1'b0;
    ref_rd_addr_o = '0;
    nb_rd_en_o    = 1'b0;
    nb_rd_addr_o  = '0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          num_ref_d  = num_ref_i;
          num_nb_d   = num_nb_i;
          num_home_d = num_home_i;
          base_d     = '0;
          slot_d     = '0;
          state_d    = (num_ref_i == '0) ? StDone : StLoadRef;
        end
      end
      StLoadRef: begin
        ref_rd_en_o      = 1'b1;
        ref_rd_addr_o    = slot_base[IdWidth-1:0];
        latch_d          = {{(NumFilter-1){1'b0}}, 1'b1} << slot_q;
        active_d[slot_q] = slot_base < {1'b0, num_ref_q};
        if (slot_q == LastSlot) begin
          slot_d  = '0;
          cnt_d   = '0;
          state_d = StPair;
        end else begin
          slot_d = slot_q + SlotW'(1);
        end
      end
      StPair: begin
        // Reaching the end count implies the last pair is on the outputs this cycle.
        if (cnt_q == {1'b0, num_nb_q}) begin
          drain_d = '0;
          state_d = StDrain;
        end else if (!stall) begin
          nb_rd_en_o   = 1'b1;
          nb_rd_addr_o = cnt_q[IdWidth-1:0];
          nb_id_d      = cnt_q[IdWidth-1:0];
          pv_d         = active_q & home_mask;
          cnt_d        = cnt_q + CntW'(1);
        end
      end
      StDrain: begin
        if (drain_q != DrainLast) begin
          drain_d = drain_q + DrainW'(1);
        end else if (all_buffer_empty_i) begin
          state_d = StNext;
        end
      end
      StNext: begin
        base_d  = base_inc;
        slot_d  = '0;
        state_d = (base_inc >= {1'b0, num_ref_q}) ? StDone : StLoadRef;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign done_d = (state_q == StDone);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      num_ref_q  <= '0;
      num_nb_q   <= '0;
      num_home_q <= '0;
      base_q     <= '0;
      cnt_q      <= '0;
      slot_q     <= '0;
      drain_q    <= '0;
      active_q   <= '0;
      latch_q    <= '0;
      pv_q       <= '0;
      nb_id_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_ref_q  <= num_ref_d;
      num_nb_q   <= num_nb_d;
      num_home_q <= num_home_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      drain_q    <= drain_d;
      active_q   <= active_d;
      latch_q    <= latch_d;
      pv_q       <= pv_d;
      nb_id_q    <= nb_id_d;
      done_q     <= done_d;
    end
  end

  // done is registered off the DONE state, so busy covers that extra cycle too.
  assign ref_latch_en_o    = latch_q;
  assign pair_valid_o      = pv_q;
  assign nb_particle_id_o  = nb_id_q;
  assign ref_particle_id_o = (state_q == StNext) ? base_inc[IdWidth-1:0] : base_q[IdWidth-1:0];
  assign done_o            = done_q;
  assign busy_o            = (state_q != StIdle) | done_q;

endmodule

// File: tb/tb_rl_pair_scheduler.sv
// Directed bench for rl_pair_scheduler: hand-computed pair masks, latch order, stall and drain.
module tb_rl_pair_scheduler;

  logic       clk, rst, start;
  logic [7:0] num_ref, num_nb, num_home;
  logic       ref_rd_en, nb_rd_en, busy, done;
  logic [7:0] ref_rd_addr, nb_rd_addr, latch, pv, nb_id, ref_id, bp;
  logic       empty;

  int n_cmp = 0;
  int n_bad = 0;

  rl_pair_scheduler dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .start_i            (start),
    .num_ref_i          (num_ref),
    .num_nb_i           (num_nb),
    .num_home_i         (num_home),
    .ref_rd_en_o        (ref_rd_en),
    .ref_rd_addr_o      (ref_rd_addr),
    .ref_latch_en_o     (latch),
    .nb_rd_en_o         (nb_rd_en),
    .nb_rd_addr_o       (nb_rd_addr),
    .pair_valid_o       (pv),
    .nb_particle_id_o   (nb_id),
    .ref_particle_id_o  (ref_id),
    .back_pressure_i    (bp),
    .all_buffer_empty_i (empty),
    .busy_o             (busy),
    .done_o             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: logs the pair presented one cycle after each neighbor issue.
  int         n_pairs = 0, n_done = 0, n_ref_rd = 0, n_nb_rd = 0;
  logic [7:0] pv_log[$], id_log[$], rid_log[$], latch_log[$];
  logic       prev_issue = 1'b0;

  always @(negedge clk) begin
    if (prev_issue) begin
      pv_log.push_back(pv);
      id_log.push_back(nb_id);
      rid_log.push_back(ref_id);
      n_pairs <= n_pairs + $countones(pv);
    end
    if (latch != 8'h00) latch_log.push_back(latch);
    if (done) n_done <= n_done + 1;
    if (ref_rd_en) n_ref_rd <= n_ref_rd + 1;
    if (nb_rd_en) n_nb_rd <= n_nb_rd + 1;
    prev_issue <= nb_rd_en;
  end

  int s_pv, s_lt, s_pairs, s_done, s_ref, s_nb;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_pv    = pv_log.size();
    s_lt    = latch_log.size();
    s_pairs = n_pairs;
    s_done  = n_done;
    s_ref   = n_ref_rd;
    s_nb    = n_nb_rd;
  endtask

  task automatic start_pass(input logic [7:0] r, input logic [7:0] n, input logic [7:0] h);
    num_ref  = r;
    num_nb   = n;
    num_home = h;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    step();
    check_eq({tag, "_busy_low"}, {30'd0, busy, done}, 32'd0);
  endtask

  task automatic wait_issue(input logic [7:0] a, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (nb_rd_en && nb_rd_addr == a) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq({tag, "_issue_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    int cnt;
    bit seen;
    rst = 1'b1; start = 1'b0; num_ref = '0; num_nb = '0; num_home = '0;
    bp = '0; empty = 1'b1;
    repeat (3) step();
    check_eq("rst_ctl", {28'd0, ref_rd_en, nb_rd_en, busy, done}, 32'd0);
    check_eq("rst_data", {latch, pv, ref_id, nb_id}, 32'd0);
    check_eq("rst_addr", {16'd0, ref_rd_addr, nb_rd_addr}, 32'd0);
    rst = 1'b0;
    step();

    // Single full group, no home particles, with cycle-accurate start timing
    snap();
    start_pass(8'd8, 8'd3, 8'd0);
    check_eq("t1_c1_rd", {ref_rd_en, ref_rd_addr, busy, latch}, {1'b1, 8'd0, 1'b1, 8'h00});
    step();
    check_eq("t1_c2_latch", {latch, ref_rd_addr}, {8'h01, 8'd1});
    repeat (7) step();
    check_eq("t1_c9_pair", {latch, nb_rd_en, nb_rd_addr}, {8'h80, 1'b1, 8'd0});
    step();
    check_eq("t1_c10_pv", {pv, nb_id}, {8'hFF, 8'd0});
    wait_done("t1");
    check_eq("t1_latch_cnt", latch_log.size() - s_lt, 32'd8);
    for (int k = 0; k < 8; k++) check_eq("t1_latch", latch_log[s_lt+k], 32'd1 << k);
    check_eq("t1_pair_cnt", pv_log.size() - s_pv, 32'd3);
    for (int k = 0; k < 3; k++) check_eq("t1_pv_id", {pv_log[s_pv+k], id_log[s_pv+k]},
                                         {8'hFF, 8'(k)});
    check_eq("t1_pairs", n_pairs - s_pairs, 32'd24);
    check_eq("t1_ndone", n_done - s_done, 32'd1);
    check_eq("t1_reads", {n_ref_rd - s_ref, n_nb_rd - s_nb}, {32'd8, 32'd3});

    // Partial second group: lanes 0,1 only
    snap();
    start_pass(8'd10, 8'd2, 8'd0);
    wait_done("t2");
    check_eq("t2_pair_cnt", pv_log.size() - s_pv, 32'd4);
    check_eq("t2_pv", {pv_log[s_pv], pv_log[s_pv+1], pv_log[s_pv+2], pv_log[s_pv+3]},
             32'hFFFF0303);
    check_eq("t2_rid", {rid_log[s_pv], rid_log[s_pv+1], rid_log[s_pv+2], rid_log[s_pv+3]},
             32'h00000808);
    check_eq("t2_ids", {id_log[s_pv], id_log[s_pv+1], id_log[s_pv+2], id_log[s_pv+3]},
             32'h00010001);
    check_eq("t2_pairs", n_pairs - s_pairs, 32'd20);
    check_eq("t2_ref_reads", n_ref_rd - s_ref, 32'd16);

    // Home-cell triangle: neighbor j pairs with references 0..j-1
    snap();
    start_pass(8'd8, 8'd8, 8'd8);
    wait_done("t3");
    check_eq("t3_pair_cnt", pv_log.size() - s_pv, 32'd8);
    for (int j = 0; j < 8; j++) check_eq("t3_pv", pv_log[s_pv+j], (32'd1 << j) - 32'd1);
    check_eq("t3_pairs", n_pairs - s_pairs, 32'd28);

    // Back-pressure on an active lane for 5 cycles
    snap();
    start_pass(8'd8, 8'd20, 8'd0);
    wait_issue(8'd5, "t4");
    step();
    bp = 8'h08;
    #1;
    check_eq("t4_inflight", {nb_rd_en, pv, nb_id}, {1'b0, 8'hFF, 8'd5});
    cnt = 0;
    for (int k = 1; k < 5; k++) begin
      step();
      #1;
      if (nb_rd_en) cnt++;
      if (k == 1) check_eq("t4_stall_pv", pv, 32'd0);
    end
    check_eq("t4_stall_issues", cnt, 32'd0);
    step();
    bp = 8'h00;
    #1;
    check_eq("t4_resume", {nb_rd_en, nb_rd_addr}, {1'b1, 8'd6});
    wait_done("t4");
    check_eq("t4_pair_cnt", pv_log.size() - s_pv, 32'd20);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (id_log[s_pv+k] != 8'(k) || pv_log[s_pv+k] != 8'hFF) cnt++;
    end
    check_eq("t4_contiguous", cnt, 32'd0);

    // Back-pressure on an inactive lane must not stall
    snap();
    bp = 8'h80;
    start_pass(8'd3, 8'd6, 8'd0);
    wait_issue(8'd0, "t5");
    cnt = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (nb_rd_en) cnt++;
    end
    check_eq("t5_no_stall", cnt, 32'd6);
    wait_done("t5");
    bp = 8'h00;
    check_eq("t5_pairs", n_pairs - s_pairs, 32'd18);
    check_eq("t5_pv0", pv_log[s_pv], 32'h07);

    // Drain holds until all_buffer_empty rises
    snap();
    empty = 1'b0;
    start_pass(8'd16, 8'd2, 8'd0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (pv != 8'h00 && nb_id == 8'd1) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("t6_last_pair_seen", 32'(seen), 32'd1);
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (ref_id != 8'd0 || ref_rd_en || nb_rd_en || !busy) cnt++;
    end
    check_eq("t6_held", cnt, 32'd0);
    empty = 1'b1;
    step();
    check_eq("t6_next_rid", {ref_id, ref_rd_en}, {8'd8, 1'b0});
    step();
    check_eq("t6_load2", {ref_rd_en, ref_rd_addr}, {1'b1, 8'd8});
    wait_done("t6");
    check_eq("t6_pairs", n_pairs - s_pairs, 32'd32);

    // Reset in the middle of PAIR, then a clean pass
    start_pass(8'd8, 8'd50, 8'd0);
    wait_issue(8'd3, "t7");
    rst = 1'b1;
    step();
    check_eq("t7_ctl", {28'd0, ref_rd_en, nb_rd_en, busy, done}, 32'd0);
    check_eq("t7_data", {latch, pv, ref_id, nb_id}, 32'd0);
    check_eq("t7_addr", {16'd0, ref_rd_addr, nb_rd_addr}, 32'd0);
    rst = 1'b0;
    step();
    snap();
    start_pass(8'd8, 8'd3, 8'd0);
    wait_done("t7b");
    check_eq("t7_pairs", n_pairs - s_pairs, 32'd24);
    check_eq("t7_ids", {8'd0, id_log[s_pv], id_log[s_pv+1], id_log[s_pv+2]}, 32'h00000102);

    // Empty reference cell: done at cycle 2, no memory reads
    snap();
    start_pass(8'd0, 8'd5, 8'd0);
    check_eq("t8_c1", {30'd0, busy, done}, 32'd2);
    step();
    check_eq("t8_c2", {30'd0, busy, done}, 32'd3);
    step();
    check_eq("t8_c3", {30'd0, busy, done}, 32'd0);
    check_eq("t8_reads", {n_ref_rd - s_ref, n_nb_rd - s_nb}, 64'd0);
    check_eq("t8_ndone", n_done - s_done, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
